cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 unit for the pipelined MIPS core. It consumes the decoded COP0 and exception flags produced by ALU control: mtc0, mfc0, eret, unknown-function, plus ALU overflow and external interrupt lines. It holds Count/Compare/Status/Cause/EPC, arbitrates exceptions and interrupts, and issues a registered one-cycle PC redirect with a flush to the fetch/hazard logic.

## Interface
- EXC_VECTOR, 32'h0000_0180, redirect target for every exception and interrupt
- COUNT_DIV, 2, clock cycles per Count increment (>=1)

- i_clk  in  1  core clock
- i_rst  in  1  reset, asynchronous, active-high
- i_stall  in  1  stage stalled; no instruction events sampled this cycle
- i_mtc0  in  1  move-to-CP0 in stage
- i_mfc0  in  1  move-from-CP0 in stage (read-only; no state change)
- i_eret  in  1  exception return in stage
- i_unknown_func  in  1  reserved instruction in stage
- i_overflow  in  1  arithmetic overflow of instruction in stage
- i_rd_addr  in  5  CP0 register number (rd field)
- i_wdata  in  32  mtc0 write data (rt value)
- i_pc  in  32  PC of instruction in stage
- i_ext_int  in  6  asynchronous hardware interrupt lines
- o_rdata  out  32  combinational read of CP0 register i_rd_addr
- o_redirect  out  1  one-cycle pulse: flush pipeline, load PC from o_target
- o_target  out  32  redirect PC
- o_exl  out  1  Status.EXL

## Operation
- Registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14). Other addresses read 0; writes to them are ignored.
- Status: IM[15:8], EXL[1], IE[0]. Writable by mtc0. All other bits read 0.
- Cause: TI[30], IP[15:10] (read-only), ExcCode[6:2]. mtc0 to Cause is ignored.
- IP[15:10] = {sync_int[5] | TI, sync_int[4:0]}. sync_int is i_ext_int passed through 2 flops.
- Count increments by 1 (mod 2^32) when the prescaler reaches COUNT_DIV-1. mtc0 Count loads i_wdata and clears the prescaler; the write wins over a same-cycle increment.
- TI sets when Count increments to a value equal to Compare. mtc0 Compare loads i_wdata and clears TI; the clear wins over a same-cycle set.
- int_pend = IE & ~EXL & |(IP & IM[15:10]).
- Event sampling happens only in state RUN with i_stall=0. Priority is fixed: interrupt (ExcCode 0) > reserved instr (10) > overflow (12) > eret > mtc0.
- Exception/interrupt: EPC<=i_pc, ExcCode<=code, EXL<=1, o_target<=EXC_VECTOR, o_redirect<=1. A same-cycle mtc0/eret is suppressed.
- eret: EXL<=0, o_target<=EPC, o_redirect<=1. eret with EXL=0 still redirects.
- FSM:
  - RUN -> FLUSH on any redirect.
  - FLUSH -> RUN unconditionally after 1 cycle. In FLUSH, all instruction inputs and int_pend are ignored, because the stage holds a squashed instruction.
- o_rdata reflects register values before the current cycle's write. mtc0 becomes visible the next cycle.
- Count, prescaler, TI and sync_int continue during stall and FLUSH.

## Timing
- Reset values:
  - Count=0, Compare=0, prescaler=0
  - Status=0 (IE=0, EXL=0, IM=0)
  - Cause=0, EPC=0, sync_int=0
  - state=RUN, o_redirect=0, o_target=0, o_exl=0
  - o_rdata = 0 at reset for every address.
- Event sampled at edge N -> o_redirect=1 with valid o_target during cycle N..N+1. It is deasserted at the next edge.
- Back-to-back redirect is impossible: minimum spacing is 2 cycles.
- i_ext_int to IP visible: 2 edges, then 1 more edge to redirect.
- Reset asserted mid-FLUSH: state and o_redirect clear immediately; no pending event is retained.

## Test plan
- Reset, mtc0 Status=32'h0000_8001, mtc0 Compare=5, COUNT_DIV=2 -> Count reaches 5 after 10 cycles. Then TI=1, IP[15]=1, and o_redirect pulses with o_target=32'h180, EPC=current i_pc, ExcCode=0, EXL=1.
- i_unknown_func=1 with i_overflow=1 at i_pc=32'h0040_0010 -> one redirect pulse to 32'h180, ExcCode=10, EPC=32'h0040_0010.
- After exception (EPC=32'h0040_0020), i_eret=1 -> o_redirect with o_target=32'h0040_0020, EXL=0. The next cycle (FLUSH) ignores i_overflow=1.
- mtc0 Count=32'hFFFF_FFFF, Compare=0, IE=0 -> Count wraps to 0, TI=1 and no redirect. mtc0 Compare=7 clears TI.
- i_stall=1 with i_unknown_func=1 for 3 cycles -> no redirect. Release stall -> redirect on the next edge.
- mfc0 rd=14 in the same cycle as mtc0 rd=14 (EPC write ignored? no: writable) -> o_rdata shows the old value. Write rd=12 then read -> new value the next cycle. Read rd=3 -> 0.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: Count/Compare timer, Status/Cause/EPC,
// exception/interrupt arbitration and a registered one-cycle PC redirect with flush.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_mtc0,
  input  logic        i_mfc0,
  input  logic        i_eret,
  input  logic        i_unknown_func,
  input  logic        i_overflow,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  input  logic [5:0]  i_ext_int,
  output logic [31:0] o_rdata,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_exl
);

  // state    | meaning
  // ST_RUN   | normal operation, instruction events and interrupts sampled
  // ST_FLUSH | redirect issued, stage holds a squashed instruction
  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [31:0] PRESC_LAST = 32'(COUNT_DIV - 1);
  localparam logic [4:0]  A_COUNT    = 5'd9;
  localparam logic [4:0]  A_COMPARE  = 5'd11;
  localparam logic [4:0]  A_STATUS   = 5'd12;
  localparam logic [4:0]  A_CAUSE    = 5'd13;
  localparam logic [4:0]  A_EPC      = 5'd14;

  state_t      r_state;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_presc;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_ti;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic        r_redirect;
  logic [31:0] r_target;

  logic [5:0]  w_ip;
  logic        w_int_pend;
  logic        w_sample;
  logic        w_exc;
  logic [4:0]  w_exc_code;
  logic        w_do_eret;
  logic        w_do_mtc0;
  logic        w_tick;
  logic [31:0] w_count_inc;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_unused;

  // mfc0 is a pure read; o_rdata is always driven from i_rd_addr.
  assign w_unused = i_mfc0;

  assign w_ip        = {r_sync2[5] | r_ti, r_sync2[4:0]};
  assign w_int_pend  = r_ie & ~r_exl & (|(w_ip & r_im[7:2]));
  assign w_sample    = (r_state == ST_RUN) & ~i_stall;
  assign w_exc       = w_sample & (w_int_pend | i_unknown_func | i_overflow);
  assign w_do_eret   = w_sample & ~w_exc & i_eret;
  assign w_do_mtc0   = w_sample & ~w_exc & ~i_eret & i_mtc0;
  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_count_inc = r_count + 32'd1;
  assign w_wr_count   = w_do_mtc0 & (i_rd_addr == A_COUNT);
  assign w_wr_compare = w_do_mtc0 & (i_rd_addr == A_COMPARE);

  always_comb begin
    w_exc_code = 5'd12;
    if (w_int_pend)          w_exc_code = 5'd0;
    else if (i_unknown_func) w_exc_code = 5'd10;
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_rd_addr)
      A_COUNT:   o_rdata = r_count;
      A_COMPARE: o_rdata = r_compare;
      A_STATUS:  o_rdata = {16'd0, r_im, 6'd0, r_exl, r_ie};
      A_CAUSE:   o_rdata = {1'b0, r_ti, 14'd0, w_ip, 3'd0, r_exccode, 2'd0};
      A_EPC:     o_rdata = r_epc;
      default:   o_rdata = 32'd0;
    endcase
  end

  // Timer keeps running through stalls and flushes; software writes win over ticks.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_presc   <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= i_wdata;
        r_presc <= 32'd0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_presc <= 32'd0;
      end else begin
        r_presc <= r_presc + 32'd1;
      end
      if (w_wr_compare) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (w_tick && !w_wr_count && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 6'd0;
      r_sync2 <= 6'd0;
    end else begin
      r_sync1 <= i_ext_int;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_redirect <= 1'b0;
      r_target   <= 32'd0;
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_exccode  <= 5'd0;
      r_epc      <= 32'd0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_exc) begin
            r_epc      <= i_pc;
            r_exccode  <= w_exc_code;
            r_exl      <= 1'b1;
            r_target   <= EXC_VECTOR;
            r_redirect <= 1'b1;
            r_state    <= ST_FLUSH;
          end else if (w_do_eret) begin
            r_exl      <= 1'b0;
            r_target   <= r_epc;
            r_redirect <= 1'b1;
            r_state    <= ST_FLUSH;
          end else if (w_do_mtc0) begin
            if (i_rd_addr == A_STATUS) begin
              r_im  <= i_wdata[15:8];
              r_exl <= i_wdata[1];
              r_ie  <= i_wdata[0];
            end else if (i_rd_addr == A_EPC) begin
              r_epc <= i_wdata;
            end
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  assign o_redirect = r_redirect;
  assign o_target   = r_target;
  assign o_exl      = r_exl;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus random traffic, all checked against a
// behavioural model that derives Count from elapsed cycles and applies CP0 rules directly.
module tb_cp0_unit;
  localparam int DIV = 2;

  logic        i_clk, i_rst, i_stall, i_mtc0, i_mfc0, i_eret, i_unknown_func, i_overflow;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_wdata, i_pc;
  logic [5:0]  i_ext_int;
  logic [31:0] o_rdata, o_target;
  logic        o_redirect, o_exl;

  int n_checks = 0;
  int n_errors = 0;

  cp0_unit #(.EXC_VECTOR(32'h0000_0180), .COUNT_DIV(DIV)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_mtc0(i_mtc0), .i_mfc0(i_mfc0),
    .i_eret(i_eret), .i_unknown_func(i_unknown_func), .i_overflow(i_overflow),
    .i_rd_addr(i_rd_addr), .i_wdata(i_wdata), .i_pc(i_pc), .i_ext_int(i_ext_int),
    .o_rdata(o_rdata), .o_redirect(o_redirect), .o_target(o_target), .o_exl(o_exl));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: Count = value last loaded + elapsed cycles / DIV.
  logic [31:0] m_base, m_compare, m_epc, m_target;
  int unsigned m_cyc;
  logic [7:0]  m_im;
  logic [4:0]  m_exc;
  bit          m_exl, m_ie, m_ti, m_flush, m_redirect;
  logic [5:0]  m_hist[$];

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_cyc / DIV);
  endfunction

  function automatic logic [5:0] m_ip();
    logic [5:0] s;
    s = m_hist[1];
    return {s[5] | m_ti, s[4:0]};
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return {16'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13:   return {1'b0, m_ti, 14'd0, m_ip(), 3'd0, m_exc, 2'd0};
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_base = 0; m_cyc = 0; m_compare = 0; m_epc = 0; m_target = 0;
    m_im = 0; m_exc = 0; m_exl = 0; m_ie = 0; m_ti = 0; m_flush = 0; m_redirect = 0;
    m_hist = {6'd0, 6'd0};
  endtask

  task automatic idle();
    i_stall = 0; i_mtc0 = 0; i_mfc0 = 0; i_eret = 0; i_unknown_func = 0; i_overflow = 0;
  endtask

  // Advance model by one clock using current inputs, then wait past the DUT edge.
  task automatic tick();
    logic [31:0] c_old, c_new;
    bit ev, intp, wr_cnt, wr_cmp;
    c_old = m_count();
    ev = !m_flush && !i_stall;
    intp = m_ie && !m_exl && ((m_ip() & m_im[7:2]) != 6'd0);
    wr_cnt = 0; wr_cmp = 0; m_redirect = 0;
    if (ev && (intp || i_unknown_func || i_overflow)) begin
      m_epc = i_pc; m_exc = intp ? 5'd0 : (i_unknown_func ? 5'd10 : 5'd12);
      m_exl = 1; m_target = 32'h180; m_redirect = 1;
    end else if (ev && i_eret) begin
      m_exl = 0; m_target = m_epc; m_redirect = 1;
    end else if (ev && i_mtc0) begin
      case (i_rd_addr)
        5'd9:  wr_cnt = 1;
        5'd11: wr_cmp = 1;
        5'd12: begin m_im = i_wdata[15:8]; m_exl = i_wdata[1]; m_ie = i_wdata[0]; end
        5'd14: m_epc = i_wdata;
        default: ;
      endcase
    end
    m_flush = m_redirect;
    if (wr_cnt) begin m_base = i_wdata; m_cyc = 0; end
    else m_cyc++;
    c_new = m_count();
    if (wr_cmp) begin m_compare = i_wdata; m_ti = 0; end
    else if (!wr_cnt && c_new != c_old && c_new == m_compare) m_ti = 1;
    m_hist.push_front(i_ext_int);
    void'(m_hist.pop_back());
    @(posedge i_clk); #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); i_mtc0 = 1; i_rd_addr = a; i_wdata = d;
    tick(); idle();
  endtask

  task automatic do_reset();
    idle(); i_ext_int = 0; i_rd_addr = 0; i_wdata = 0; i_pc = 0;
    i_rst = 1; model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL reset_redirect got=%0b exp=0", o_redirect); end
    n_checks++; if (o_target !== 32'd0) begin n_errors++; $display("FAIL reset_target got=%h exp=0", o_target); end
    n_checks++; if (o_exl !== 1'b0) begin n_errors++; $display("FAIL reset_exl got=%0b exp=0", o_exl); end
    for (int a = 0; a < 32; a++) begin
      i_rd_addr = 5'(a); #1;
      n_checks++; if (o_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata addr=%0d got=%h exp=0", a, o_rdata); end
    end
  endtask

  task automatic test_timer_int();
    logic [31:0] pc;
    do_reset();
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    repeat (8) tick();
    i_rd_addr = 5'd9; #1;
    n_checks++; if (o_rdata !== 32'd5 || o_rdata !== m_rdata(5'd9)) begin n_errors++; $display("FAIL timer_count got=%h exp=5", o_rdata); end
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[30] !== 1'b1 || o_rdata[15] !== 1'b1) begin n_errors++; $display("FAIL timer_ti got=%h exp TI=1 IP7=1", o_rdata); end
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL timer_early got=%0b exp=0", o_redirect); end
    pc = $urandom & 32'hFFFF_FFFC; i_pc = pc;
    tick();
    n_checks++; if (o_redirect !== 1'b1 || o_target !== 32'h180) begin n_errors++; $display("FAIL timer_redirect got=%0b/%h exp=1/180", o_redirect, o_target); end
    n_checks++; if (o_exl !== 1'b1) begin n_errors++; $display("FAIL timer_exl got=%0b exp=1", o_exl); end
    i_rd_addr = 5'd14; #1;
    n_checks++; if (o_rdata !== pc) begin n_errors++; $display("FAIL timer_epc got=%h exp=%h", o_rdata, pc); end
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[6:2] !== 5'd0) begin n_errors++; $display("FAIL timer_exccode got=%0d exp=0", o_rdata[6:2]); end
    tick();
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL timer_pulse_end got=%0b exp=0", o_redirect); end
  endtask

  task automatic test_reserved();
    tick();
    i_unknown_func = 1; i_overflow = 1; i_pc = 32'h0040_0010;
    tick(); idle();
    n_checks++; if (o_redirect !== 1'b1 || o_target !== 32'h180) begin n_errors++; $display("FAIL rsv_redirect got=%0b/%h exp=1/180", o_redirect, o_target); end
    tick();
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL rsv_single got=%0b exp=0", o_redirect); end
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[6:2] !== 5'd10) begin n_errors++; $display("FAIL rsv_exccode got=%0d exp=10", o_rdata[6:2]); end
    i_rd_addr = 5'd14; #1;
    n_checks++; if (o_rdata !== 32'h0040_0010) begin n_errors++; $display("FAIL rsv_epc got=%h exp=00400010", o_rdata); end
  endtask

  task automatic test_eret();
    mtc0(5'd11, 32'hFFFF_0000);
    i_overflow = 1; i_pc = 32'h0040_0020;
    tick(); idle();
    n_checks++; if (o_redirect !== 1'b1) begin n_errors++; $display("FAIL eret_exc got=%0b exp=1", o_redirect); end
    tick();
    i_eret = 1;
    tick(); idle();
    n_checks++; if (o_redirect !== 1'b1 || o_target !== 32'h0040_0020) begin n_errors++; $display("FAIL eret_target got=%0b/%h exp=1/00400020", o_redirect, o_target); end
    n_checks++; if (o_exl !== 1'b0) begin n_errors++; $display("FAIL eret_exl got=%0b exp=0", o_exl); end
    i_overflow = 1;
    tick(); idle();
    n_checks++; if (o_redirect !== 1'b0 || o_redirect !== m_redirect) begin n_errors++; $display("FAIL eret_flush_ignore got=%0b exp=0", o_redirect); end
    tick();
  endtask

  task automatic test_wrap();
    mtc0(5'd12, 32'd0);
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    for (int k = 0; k < DIV; k++) begin
      tick();
      n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL wrap_no_redirect cyc=%0d got=%0b exp=0", k, o_redirect); end
    end
    i_rd_addr = 5'd9; #1;
    n_checks++; if (o_rdata !== 32'd0) begin n_errors++; $display("FAIL wrap_count got=%h exp=0", o_rdata); end
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[30] !== 1'b1) begin n_errors++; $display("FAIL wrap_ti got=%0b exp=1", o_rdata[30]); end
    mtc0(5'd11, 32'd7);
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[30] !== 1'b0) begin n_errors++; $display("FAIL wrap_ti_clear got=%0b exp=0", o_rdata[30]); end
  endtask

  task automatic test_stall();
    i_stall = 1; i_unknown_func = 1; i_pc = 32'h0040_0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL stall_hold cyc=%0d got=%0b exp=0", k, o_redirect); end
    end
    i_stall = 0;
    tick(); idle();
    n_checks++; if (o_redirect !== 1'b1 || o_target !== 32'h180) begin n_errors++; $display("FAIL stall_release got=%0b/%h exp=1/180", o_redirect, o_target); end
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[6:2] !== 5'd10) begin n_errors++; $display("FAIL stall_exccode got=%0d exp=10", o_rdata[6:2]); end
    tick();
  endtask

  task automatic test_rdata();
    logic [31:0] old, nw, st;
    old = m_epc; nw = $urandom;
    idle(); i_mtc0 = 1; i_mfc0 = 1; i_rd_addr = 5'd14; i_wdata = nw; #1;
    n_checks++; if (o_rdata !== old) begin n_errors++; $display("FAIL rd_same_cycle got=%h exp=%h", o_rdata, old); end
    tick(); idle(); #1;
    n_checks++; if (o_rdata !== nw) begin n_errors++; $display("FAIL rd_epc_new got=%h exp=%h", o_rdata, nw); end
    st = $urandom | 32'h2;
    mtc0(5'd12, st);
    i_mfc0 = 1; i_rd_addr = 5'd12; #1;
    n_checks++; if (o_rdata !== (st & 32'h0000_FF03)) begin n_errors++; $display("FAIL rd_status got=%h exp=%h", o_rdata, st & 32'h0000_FF03); end
    i_rd_addr = 5'd3; #1;
    n_checks++; if (o_rdata !== 32'd0) begin n_errors++; $display("FAIL rd_unmapped got=%h exp=0", o_rdata); end
    idle();
  endtask

  task automatic test_ext_int();
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    i_ext_int = 6'b000001; i_pc = 32'h0040_0200;
    tick();
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL ext_edge1 got=%0b exp=0", o_redirect); end
    tick();
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL ext_edge2 got=%0b exp=0", o_redirect); end
    i_rd_addr = 5'd13; #1;
    n_checks++; if (o_rdata[10] !== 1'b1) begin n_errors++; $display("FAIL ext_ip got=%0b exp=1", o_rdata[10]); end
    tick();
    n_checks++; if (o_redirect !== 1'b1 || o_target !== 32'h180) begin n_errors++; $display("FAIL ext_redirect got=%0b/%h exp=1/180", o_redirect, o_target); end
    i_ext_int = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    i_unknown_func = 1;
    tick(); idle();
    n_checks++; if (o_redirect !== 1'b1) begin n_errors++; $display("FAIL rstf_pre got=%0b exp=1", o_redirect); end
    i_rst = 1; #1;
    n_checks++; if (o_redirect !== 1'b0 || o_exl !== 1'b0) begin n_errors++; $display("FAIL rstf_async got=%0b/%0b exp=0/0", o_redirect, o_exl); end
    do_reset();
    tick();
    n_checks++; if (o_redirect !== 1'b0) begin n_errors++; $display("FAIL rstf_no_pending got=%0b exp=0", o_redirect); end
  endtask

  task automatic test_random();
    logic [4:0] addrs[7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
    int r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      idle();
      i_stall = ($urandom_range(7) == 0);
      i_pc = $urandom;
      i_rd_addr = addrs[$urandom_range(6)];
      i_mfc0 = $urandom_range(1);
      r = $urandom_range(15);
      if (r == 0) i_unknown_func = 1;
      if (r == 1) i_overflow = 1;
      if (r == 2 || r == 3) i_eret = 1;
      if (r >= 3 && r <= 8) begin
        i_mtc0 = 1;
        i_wdata = ($urandom_range(1) == 1) ? m_count() + 32'($urandom_range(6)) : $urandom;
      end
      if ($urandom_range(9) == 0) i_ext_int = 6'($urandom);
      #1;
      n_checks++; if (o_rdata !== m_rdata(i_rd_addr)) begin n_errors++; $display("FAIL rnd_rdata cyc=%0d addr=%0d got=%h exp=%h", k, i_rd_addr, o_rdata, m_rdata(i_rd_addr)); end
      tick();
      n_checks++; if (o_redirect !== m_redirect || o_target !== m_target || o_exl !== m_exl) begin
        n_errors++; $display("FAIL rnd_out cyc=%0d got=%0b/%h/%0b exp=%0b/%h/%0b", k, o_redirect, o_target, o_exl, m_redirect, m_target, m_exl);
      end
    end
  endtask

  initial begin
    i_rst = 1; i_ext_int = 0; i_rd_addr = 0; i_wdata = 0; i_pc = 0; idle();
    test_reset();
    test_timer_int();
    test_reserved();
    test_eret();
    test_wrap();
    test_stall();
    test_rdata();
    test_ext_int();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
